// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage owns the port by default, and a debug/DMA
// master is forced in after STARVE_LIMIT lost cycles. Completions are tracked by an owner tag.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic { D_IDLE, D_BUSY } dstate_t;
    typedef enum logic [1:0] { OWN_NONE, OWN_CPU, OWN_DBG } owner_t;

    dstate_t          state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rd_q, rd_d;
    logic             dbg_elig, dbg_win, cpu_win;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= D_IDLE;
            owner_q <= OWN_NONE;
            wait_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = OWN_NONE;
        wait_d    = wait_q;
        rd_d      = 1'b0;
        cpu_stall = 1'b0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        dbg_gnt   = 1'b0;
        dbg_ack   = 1'b0;
        dbg_rdata = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Nothing issues or completes while reset is low, so an in-flight access is dropped.
        dbg_elig = resetn && dbg_req && (state_q == D_IDLE);
        dbg_win  = dbg_elig && (!cpu_req || (wait_q == LIMIT));
        cpu_win  = resetn && cpu_req && !dbg_win;

        case (state_q)
            D_IDLE:  if (dbg_win) state_d = D_BUSY;
            D_BUSY:  state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase

        if (!dbg_req || dbg_win) begin
            wait_d = '0;
        end else if (dbg_elig && cpu_win && (wait_q != LIMIT)) begin
            wait_d = wait_q + CNT_W'(1);
        end

        if (cpu_win) begin
            owner_d   = OWN_CPU;
            rd_d      = !cpu_we;
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_win) begin
            owner_d   = OWN_DBG;
            rd_d      = !dbg_we;
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end

        dbg_gnt   = dbg_win;
        cpu_stall = cpu_req && dbg_win;

        // Read data is steered only to the owner of last cycle's read; write acks return zero.
        if (resetn && (owner_q == OWN_CPU)) begin
            cpu_ack = 1'b1;
            if (rd_q) cpu_rdata = mem_rdata;
        end
        if (resetn && (owner_q == OWN_DBG)) begin
            dbg_ack = 1'b1;
            if (rd_q) dbg_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural sync RAM, per-cycle issue checks and an ack scoreboard.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          resetn;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_stall, cpu_ack, dbg_gnt, dbg_ack;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic          preload;

    typedef struct packed {
        logic          dbg;
        logic [DW-1:0] data;
    } exp_t;
    exp_t expq[$];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 4) return 32'h0000_1234;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Synchronous RAM; returns a poison word whenever no read was issued.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            mem_rdata <= 32'hDEAD_BEEF;
        end else begin
            if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // One clock cycle with the current inputs; win: 0 = nobody, 1 = CPU, 2 = debug.
    task automatic cyc(input int win);
        exp_t e;
        @(negedge clock);
        check_eq("mem_en", mem_en, win != 0);
        check_eq("dbg_gnt", dbg_gnt, win == 2);
        check_eq("cpu_stall", cpu_stall, cpu_req && (win == 2));
        if (win == 1) begin
            check_eq("mem_we", mem_we, cpu_we);
            check_eq("mem_addr", mem_addr, cpu_addr);
            check_eq("mem_wdata", mem_wdata, cpu_wdata);
        end else if (win == 2) begin
            check_eq("mem_we", mem_we, dbg_we);
            check_eq("mem_addr", mem_addr, dbg_addr);
            check_eq("mem_wdata", mem_wdata, dbg_wdata);
        end else begin
            check_eq("mem_we_idle", mem_we, 0);
            check_eq("mem_addr_idle", mem_addr, 0);
            check_eq("mem_wdata_idle", mem_wdata, 0);
        end
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check_eq("cpu_ack", cpu_ack, !e.dbg);
            check_eq("dbg_ack", dbg_ack, e.dbg);
            check_eq("cpu_rdata", cpu_rdata, e.dbg ? 32'h0 : e.data);
            check_eq("dbg_rdata", dbg_rdata, e.dbg ? e.data : 32'h0);
        end else begin
            check_eq("cpu_ack_none", cpu_ack, 0);
            check_eq("dbg_ack_none", dbg_ack, 0);
            check_eq("cpu_rdata_none", cpu_rdata, 0);
            check_eq("dbg_rdata_none", dbg_rdata, 0);
        end
        if (win == 1) begin
            e.dbg  = 1'b0;
            e.data = cpu_we ? 32'h0 : ref_mem[cpu_addr[7:0]];
            if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
            expq.push_back(e);
        end else if (win == 2) begin
            e.dbg  = 1'b1;
            e.data = dbg_we ? 32'h0 : ref_mem[dbg_addr[7:0]];
            if (dbg_we) ref_mem[dbg_addr[7:0]] = dbg_wdata;
            expq.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        preload = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(posedge clock);
        #1;
        preload = 1'b0;

        // Reset and quiet idle afterwards
        cyc(0);
        cyc(0);
        resetn = 1'b1;
        cyc(0);
        cyc(0);

        // CPU load of word 4
        set_cpu(1, 0, 32'h4, 0);
        cyc(1);
        set_cpu(0, 0, 0, 0);
        cyc(0);

        // Debug write while idle, then CPU reads it back
        set_dbg(1, 1, 32'h10, 32'hA5A5_A5A5);
        cyc(2);
        cyc(0);
        set_dbg(0, 0, 0, 0);
        set_cpu(1, 0, 32'h10, 0);
        cyc(1);
        set_cpu(0, 0, 0, 0);
        cyc(0);

        // Starvation: CPU streams every cycle, debug forced in on cycle 8
        set_dbg(1, 0, 32'h20, 0);
        for (int i = 0; i < 10; i++) begin
            set_cpu(1, 1'(i % 2), 32'(32'h40 + i), 32'(32'h7700 + i));
            cyc((i == 8) ? 2 : 1);
        end
        set_dbg(0, 0, 0, 0);
        set_cpu(0, 0, 0, 0);
        cyc(0);

        // Simultaneous requests: CPU store first, then debug read, then CPU load
        set_cpu(1, 1, 32'hC, 32'hC0FF_EE00);
        set_dbg(1, 0, 32'h8, 32'h1111_1111);
        cyc(1);
        set_cpu(0, 0, 0, 0);
        cyc(2);
        set_cpu(1, 0, 32'hC, 0);
        cyc(1);
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        cyc(0);

        // Reset while a debug access is in flight
        set_dbg(1, 0, 32'h30, 0);
        cyc(2);
        resetn = 1'b0;
        expq.delete();
        set_cpu(1, 0, 32'h4, 0);
        cyc(0);
        resetn = 1'b1;
        set_cpu(0, 0, 0, 0);
        cyc(2);
        cyc(0);
        set_dbg(0, 0, 0, 0);
        cyc(0);

        // Alternating CPU / debug traffic with random addresses and data
        for (int i = 0; i < 50; i++) begin
            set_cpu((i % 2) == 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
            set_dbg(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
            cyc(((i % 2) == 0) ? 1 : 2);
        end
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        cyc(0);
        check_eq("scoreboard_drained", 64'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning the word address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 The module SHALL have parameter STARVE_LIMIT, default 8, meaning the maximum number of cycles a pending debug request loses to the CPU before it is forced.
REQ-004 The module SHALL have one clock and a synchronous, active-low reset, with these ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- cpu_req  in  1  MEM-stage load/store request
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  CPU lost arbitration this cycle; freeze pipeline
- cpu_ack  out  1  CPU access completed (one cycle after issue)
- cpu_rdata  out  DATA_W  CPU load data, valid with cpu_ack
- dbg_req  in  1  debug/DMA request, level, held until dbg_ack
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug access issued to memory this cycle
- dbg_ack  out  1  debug access completed (one cycle after dbg_gnt)
- dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous RAM read data, valid one cycle after mem_en

Function
REQ-005 Per cycle, at most one access SHALL issue; mem_en, mem_we, mem_addr and mem_wdata SHALL be combinational copies of the winning requester's signals, and all SHALL be 0 when no request wins.
REQ-006 Debug request eligibility SHALL be tracked by a 2-state FSM: D_IDLE, in which dbg_req is eligible, and D_BUSY, in which the debug access has been granted and dbg_req is ignored.
REQ-007 Transitions: D_IDLE->D_BUSY on dbg_gnt; D_BUSY->D_IDLE unconditionally next cycle, with dbg_ack=1 in that cycle; the earliest re-grant is the cycle after dbg_ack.
REQ-008 Priority: CPU SHALL win when cpu_req=1 and wait_cnt<STARVE_LIMIT; debug SHALL win when eligible and (cpu_req=0 or wait_cnt==STARVE_LIMIT).
REQ-009 cpu_stall SHALL be combinational, asserted exactly when cpu_req=1 and debug wins.
REQ-010 wait_cnt SHALL be a saturating counter of width ceil(log2(STARVE_LIMIT+1)):
- +1 each cycle debug is eligible, dbg_req=1 and the CPU wins;
- cleared on dbg_gnt;
- cleared whenever dbg_req=0.
REQ-011 Completion tracking: a registered owner tag {NONE, CPU, DBG} SHALL record the previous cycle's winner. cpu_ack or dbg_ack SHALL be 1 for exactly one cycle accordingly, for both reads and writes.
REQ-012 Read data: on a read ack, the owner's rdata SHALL equal mem_rdata; on a write ack and in non-ack cycles, rdata SHALL be 0.
REQ-013 Back-to-back CPU accesses SHALL issue every cycle with no bubbles, giving 100% throughput when debug is idle.
REQ-014 A CPU access issued in cycle N and a debug access issued in cycle N+1 SHALL both complete, in cycles N+1 and N+2, with no rdata mixing.
REQ-015 The CPU request SHALL NOT be latched: a stalled CPU re-presents it next cycle, and the arbiter holds no CPU state other than the owner tag.

Reset
REQ-016 While resetn=0 at a rising edge: the FSM SHALL go to D_IDLE, wait_cnt=0 and owner=NONE.
REQ-017 In the cycle after reset: cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, dbg_gnt=0 and mem_en=0 until a request arrives.
REQ-018 Reset asserted mid-operation SHALL discard the in-flight access: no ack is produced for an access issued in the cycle reset is sampled, and a held dbg_req is re-arbitrated from D_IDLE after reset release.

Verification
REQ-019 CPU load only: cpu_req=1, we=0, addr=0x4, with RAM[4]=0x1234 -> mem_en=1 the same cycle; next cycle cpu_ack=1, cpu_rdata=0x00001234; cpu_stall=0 throughout.
REQ-020 Debug write idle: dbg_req=1, we=1, addr=0x10, wdata=0xA5A5A5A5 -> dbg_gnt the same cycle; dbg_ack next cycle; a subsequent CPU load of 0x10 returns 0xA5A5A5A5.
REQ-021 Starvation: cpu_req=1 every cycle and dbg_req=1 from cycle 0 -> CPU wins cycles 0..7; cycle 8 has dbg_gnt=1 and cpu_stall=1; cycle 9 has CPU winning and dbg_ack=1.
REQ-022 Simultaneous requests, debug read addr 0x8 and CPU store addr 0xC: CPU issues first; debug is not granted in the cycle after its own gnt, so it cannot double-issue; dbg_rdata equals RAM[8], never the CPU data.
REQ-023 Reset mid-access: debug granted at cycle N, resetn=0 sampled at N+1 -> no dbg_ack and all outputs 0; after release with dbg_req still high, a fresh dbg_gnt is followed by dbg_ack.
REQ-024 Alternating CPU/debug with cpu_req=0 on odd cycles and dbg_req=1 held: each ack matches its owner, rdata matches RAM contents, and there are no lost or duplicated acks over 50 cycles.
